// File: rtl/radix4_seq_mult.sv
// Sequential radix-4 shift-add multiplier: retires two multiplier bits per clock,
// advancing the multiplicand through a 2-bit left-shift stage each iteration.

module radix4_shl2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  assign dout = {din[W-3:0], 2'b00};
endmodule

module radix4_seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int STEPS = WIDTH / 2;
  localparam int PW    = 2 * WIDTH;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     mcand, mcand_shl, pp, acc, acc_nxt;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     count;
  logic              last, accept;

  radix4_shl2 #(.W(PW)) u_shl2 (.din(mcand), .dout(mcand_shl));

  assign last   = (count == CW'(STEPS - 1));
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Partial product for the current radix-4 digit; 3x is built as 1x + 2x.
  always_comb begin
    pp = '0;
    case (mplier[1:0])
      2'd0: pp = '0;
      2'd1: pp = mcand;
      2'd2: pp = mcand << 1;
      2'd3: pp = mcand + (mcand << 1);
      default: pp = '0;
    endcase
    acc_nxt = acc + pp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= (state == CALC) && last;
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        count  <= '0;
        busy   <= 1'b1;
      end else if (state == CALC) begin
        acc    <= acc_nxt;
        mcand  <= mcand_shl;
        mplier <= mplier >> 2;
        count  <= count + CW'(1);
        // Fixed iteration count: no early exit on leading-zero multipliers.
        if (last) begin
          product <= acc_nxt;
          busy    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_radix4_seq_mult.sv
// Randomized and directed bench for radix4_seq_mult at WIDTH=4 and WIDTH=8,
// checked against plain a*b arithmetic and the STEPS-cycle latency rule.

module tb_radix4_seq_mult;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] prod4;
  logic       start8, busy8, done8;
  logic [7:0] a8, b8;
  logic [15:0] prod8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  radix4_seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4));

  radix4_seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8));

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Drives one accepted op on the 4-bit unit and reports what came back.
  task automatic op4(input logic [3:0] aa, input logic [3:0] bb,
                     output logic [7:0] p, output int lat, output logic pulse1);
    a4 = aa; b4 = bb; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    lat = -1; p = 'x; pulse1 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (done4) begin lat = i; p = prod4; break; end
    end
    if (lat > 0) begin tick; pulse1 = !done4; end
  endtask

  task automatic op8(input logic [7:0] aa, input logic [7:0] bb,
                     output logic [15:0] p, output int lat);
    a8 = aa; b8 = bb; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    lat = -1; p = 'x;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (done8) begin lat = i; p = prod8; break; end
    end
    if (lat > 0) tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start4 = 0; start8 = 0; a4 = 0; b4 = 0; a8 = 0; b8 = 0;
    #22;
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy4); end
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done4); end
    total++; if (prod4 !== 8'h00) begin bad++; $display("FAIL reset_product got=%h want=00", prod4); end
    total++; if (prod8 !== 16'h0) begin bad++; $display("FAIL reset_product8 got=%h want=0000", prod8); end
    @(negedge clk); rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL basic_busy_c0 got=%b want=1", busy4); end
    tick;
    total++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin bad++; $display("FAIL basic_c1 busy=%b done=%b want busy=1 done=0", busy4, done4); end
    tick;
    total++; if (busy4 !== 1'b0 || done4 !== 1'b1) begin bad++; $display("FAIL basic_c2 busy=%b done=%b want busy=0 done=1", busy4, done4); end
    total++; if (prod4 !== 8'hE1) begin bad++; $display("FAIL basic_product got=%h want=e1", prod4); end
    tick;
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", done4); end
  endtask

  task automatic test_corners;
    logic [3:0] av [4] = '{4'd0, 4'd9, 4'd1, 4'd3};
    logic [3:0] bv [4] = '{4'd9, 4'd0, 4'd1, 4'd2};
    logic [7:0] p, exp;
    int lat; logic pulse1;
    for (int k = 0; k < 4; k++) begin
      op4(av[k], bv[k], p, lat, pulse1);
      exp = 8'(int'(av[k]) * int'(bv[k]));
      total++; if (p !== exp) begin bad++; $display("FAIL corner_product a=%0d b=%0d got=%h want=%h", av[k], bv[k], p, exp); end
      total++; if (lat != 2) begin bad++; $display("FAIL corner_latency got=%0d want=2", lat); end
    end
  endtask

  task automatic test_back_to_back;
    int cyc[$];
    logic [7:0] prods[$];
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd7;
    tick;
    a4 = 4'd12; b4 = 4'd11;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (done4) begin cyc.push_back(i); prods.push_back(prod4); end
    end
    start4 = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    total++;
    if (cyc.size() != 2) begin
      bad++; $display("FAIL b2b_done_count got=%0d want=2", cyc.size());
    end else begin
      total++; if (cyc[1] - cyc[0] != 4) begin bad++; $display("FAIL b2b_spacing got=%0d want=4", cyc[1] - cyc[0]); end
      total++; if (prods[0] !== 8'(5 * 7)) begin bad++; $display("FAIL b2b_first got=%h want=%h", prods[0], 8'(5 * 7)); end
      total++; if (prods[1] !== 8'(12 * 11)) begin bad++; $display("FAIL b2b_second got=%h want=%h", prods[1], 8'(12 * 11)); end
    end
  endtask

  task automatic test_ignore_start;
    int extra = 0;
    a4 = 4'd6; b4 = 4'd6; start4 = 1'b1;
    tick;
    a4 = 4'd15; b4 = 4'd15;
    tick; tick;
    total++; if (done4 !== 1'b1 || prod4 !== 8'h24) begin bad++; $display("FAIL ignore_product done=%b got=%h want=24", done4, prod4); end
    tick;
    start4 = 1'b0;
    for (int i = 0; i < 6; i++) begin tick; if (done4) extra++; end
    total++; if (extra != 0) begin bad++; $display("FAIL ignore_extra_done got=%0d want=0", extra); end
    total++; if (prod4 !== 8'h24) begin bad++; $display("FAIL ignore_hold got=%h want=24", prod4); end
  endtask

  task automatic test_async_reset;
    logic [7:0] p; int lat; logic pulse1; int seen = 0;
    a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total++; if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin bad++; $display("FAIL areset_immediate busy=%b done=%b prod=%h want 0/0/00", busy4, done4, prod4); end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin tick; if (done4 || busy4) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL areset_idle activity=%0d want=0", seen); end
    total++; if (prod4 !== 8'h00) begin bad++; $display("FAIL areset_no_writeback got=%h want=00", prod4); end
    op4(4'd2, 4'd3, p, lat, pulse1);
    total++; if (p !== 8'h06) begin bad++; $display("FAIL areset_next_op got=%h want=06", p); end
  endtask

  task automatic test_exhaustive;
    logic [7:0] p, exp; int lat; logic pulse1;
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++) begin
        op4(4'(ai), 4'(bi), p, lat, pulse1);
        exp = 8'(ai * bi);
        total++; if (p !== exp) begin bad++; $display("FAIL exh_product a=%0d b=%0d got=%h want=%h", ai, bi, p, exp); end
        total++; if (lat != 2 || !pulse1) begin bad++; $display("FAIL exh_timing a=%0d b=%0d lat=%0d pulse1=%b want 2/1", ai, bi, lat, pulse1); end
      end
  endtask

  task automatic test_random4;
    logic [7:0] p, exp; int lat; logic pulse1; logic [3:0] ra, rb;
    for (int k = 0; k < 40; k++) begin
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      op4(ra, rb, p, lat, pulse1);
      exp = 8'(int'(ra) * int'(rb));
      total++; if (p !== exp) begin bad++; $display("FAIL rand4 a=%0d b=%0d got=%h want=%h", ra, rb, p, exp); end
    end
  endtask

  task automatic test_wide8;
    logic [15:0] p, exp; int lat; logic [7:0] ra, rb;
    op8(8'd200, 8'd201, p, lat);
    total++; if (p !== 16'h9D08) begin bad++; $display("FAIL w8_fixed got=%h want=9d08", p); end
    total++; if (lat != 4) begin bad++; $display("FAIL w8_latency got=%0d want=4", lat); end
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
      op8(ra, rb, p, lat);
      exp = 16'(int'(ra) * int'(rb));
      total++; if (p !== exp || lat != 4) begin bad++; $display("FAIL w8_rand a=%0d b=%0d got=%h lat=%0d want=%h lat=4", ra, rb, p, lat, exp); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_corners;
    test_back_to_back;
    test_ignore_start;
    test_async_reset;
    test_exhaustive;
    test_random4;
    test_wide8;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
